// File: rtl/led_chain_driver.sv
// Serial driver for daisy-chained 12-bit grayscale LED drivers: fetches per-channel words from a
// synchronous frame buffer and shifts them out on C_LANES chains with a shared sclk and latch.

module led_lane_shift #(
  parameter int C_BPC       = 12,
  parameter int C_MSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [C_BPC-1:0] din,
  output logic             dout
);
  logic [C_BPC-1:0] sr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   sr_q <= '0;
    else if (load)  sr_q <= din;
    else if (shift) sr_q <= (C_MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
  end

  assign dout = (C_MSB_FIRST != 0) ? sr_q[C_BPC-1] : sr_q[0];
endmodule

module led_chain_driver #(
  parameter int C_LANES        = 2,
  parameter int C_CHANNELS     = 480,
  parameter int C_ADDR_W       = $clog2(C_CHANNELS),
  parameter int C_BPC          = 12,
  parameter int C_MSB_FIRST    = 1,
  parameter int C_CLK_DIV      = 2,
  parameter int C_LAT_CYCLES   = 2,
  parameter int C_FRAME_PERIOD = 16666
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_trig_mode,
  input  logic                     i_start,
  input  logic [C_LANES*C_BPC-1:0] i_data,
  output logic [C_ADDR_W-1:0]      o_addr,
  output logic                     o_sclk,
  output logic [C_LANES-1:0]       o_dai,
  output logic                     o_lat,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overrun
);
  localparam int PER_W = (C_FRAME_PERIOD > 1) ? $clog2(C_FRAME_PERIOD) : 1;
  localparam int PH_W  = $clog2(2*C_CLK_DIV);
  localparam int BIT_W = (C_BPC > 1) ? $clog2(C_BPC) : 1;
  localparam int LAT_W = (C_LAT_CYCLES > 1) ? $clog2(C_LAT_CYCLES) : 1;

  localparam logic [PER_W-1:0]    PER_LAST  = PER_W'(C_FRAME_PERIOD-1);
  localparam logic [PH_W-1:0]     PH_LAST   = PH_W'(2*C_CLK_DIV-1);
  localparam logic [PH_W-1:0]     PH_HI     = PH_W'(C_CLK_DIV);
  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(C_BPC-1);
  localparam logic [LAT_W-1:0]    LAT_LAST  = LAT_W'(C_LAT_CYCLES-1);
  localparam logic [C_ADDR_W-1:0] ADDR_LAST = C_ADDR_W'(C_CHANNELS-1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;

  state_t               state_q, state_d;
  logic [PER_W-1:0]     per_q;
  logic [C_ADDR_W-1:0]  addr_q, addr_d;
  logic                 fetch_q, fetch_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 mode_q, mode_d;
  logic                 sclk_q, sclk_d;
  logic                 latp_q, latp_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 sh_en_q, sh_en_d;
  logic                 load, shift;
  logic                 eff_mode, start_ev;

  logic [C_LANES-1:0][C_BPC-1:0] lane_data;
  logic [C_LANES-1:0]            lane_bit;

  assign lane_data = i_data;

  // Mode is only followed while idle; a frame in flight keeps the mode it started with.
  assign eff_mode = (state_q == IDLE) ? i_trig_mode : mode_q;
  assign start_ev = eff_mode ? i_start : (per_q == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              per_q <= '0;
    else if (per_q == PER_LAST) per_q <= '0;
    else                       per_q <= per_q + PER_W'(1);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fetch_d = fetch_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    lat_d   = lat_q;
    mode_d  = mode_q;
    load    = 1'b0;
    shift   = 1'b0;
    done_d  = 1'b0;
    ovr_d   = start_ev && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        mode_d = i_trig_mode;
        if (start_ev) begin
          state_d = FETCH;
          addr_d  = '0;
          fetch_d = 1'b0;
        end
      end
      FETCH: begin
        // read data is valid in the second cycle; capture at its end
        if (fetch_q) begin
          state_d = SHIFT;
          load    = 1'b1;
          bit_d   = '0;
          ph_d    = '0;
        end else begin
          fetch_d = 1'b1;
        end
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_q == BIT_LAST) begin
            if (addr_q == ADDR_LAST) begin
              state_d = LATCH;
              lat_d   = '0;
            end else begin
              state_d = FETCH;
              addr_d  = addr_q + C_ADDR_W'(1);
              fetch_d = 1'b0;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            shift = 1'b1;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      LATCH: begin
        if (lat_q == LAT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Serial outputs come straight from flops so the chain never sees decode glitches.
    sclk_d  = (state_d == SHIFT) && (ph_d >= PH_HI);
    sh_en_d = (state_d == SHIFT);
    latp_d  = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      fetch_q <= 1'b0;
      bit_q   <= '0;
      ph_q    <= '0;
      lat_q   <= '0;
      mode_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sh_en_q <= 1'b0;
      latp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      lat_q   <= lat_d;
      mode_q  <= mode_d;
      sclk_q  <= sclk_d;
      sh_en_q <= sh_en_d;
      latp_q  <= latp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  for (genvar k = 0; k < C_LANES; k++) begin : g_lane
    led_lane_shift #(
      .C_BPC       (C_BPC),
      .C_MSB_FIRST (C_MSB_FIRST)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .load    (load),
      .shift   (shift),
      .din     (lane_data[k]),
      .dout    (lane_bit[k])
    );
  end

  assign o_addr    = addr_q;
  assign o_sclk    = sclk_q;
  assign o_dai     = lane_bit & {C_LANES{sh_en_q}};
  assign o_lat     = latp_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_overrun = ovr_q;
endmodule

// File: doc/led_chain_driver.md
Name: led_chain_driver

Overview:
- Next-generation serial driver for daisy-chained constant-current LED driver chips (12-bit grayscale shift register plus latch).
- Reads per-channel grayscale words from a synchronous frame buffer and shifts them out on several parallel chains (lanes) with a shared, register-generated serial clock. No gated clock.
- Frames start either on a free-running period or on an external trigger. The block reports busy, frame-done and overrun status to the frame-buffer controller.

Parameters:
- C_LANES, 2, number of parallel data chains sharing o_sclk and o_lat
- C_CHANNELS, 480, channels per lane (boards per lane x 32)
- C_ADDR_W, $clog2(C_CHANNELS), address width
- C_BPC, 12, bits per channel word
- C_MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
- C_CLK_DIV, 2, i_clk cycles per o_sclk half-period (>=1)
- C_LAT_CYCLES, 2, o_lat high width in i_clk cycles (>=1)
- C_FRAME_PERIOD, 16666, free-run frame period in i_clk cycles

Ports:
- i_clk, in, 1, system clock
- i_rst_n, in, 1, asynchronous active-low reset
- i_trig_mode, in, 1, 0 = free-run on period counter, 1 = start on i_start
- i_start, in, 1, single-cycle frame start request (trigger mode only)
- i_data, in, C_LANES*C_BPC, frame-buffer read data; lane k occupies bits [k*C_BPC +: C_BPC]; valid 1 cycle after o_addr
- o_addr, out, C_ADDR_W, frame-buffer read address, shared by all lanes
- o_sclk, out, 1, serial clock to all chains
- o_dai, out, C_LANES, serial data, one bit per lane
- o_lat, out, 1, latch pulse to all chains
- o_busy, out, 1, high from frame start until the last latch cycle inclusive
- o_done, out, 1, single-cycle pulse after the latch completes
- o_overrun, out, 1, single-cycle pulse when a start event is dropped because the block is busy

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0; state IDLE; period counter 0; address 0.
- Period counter:
  - Counts 0..C_FRAME_PERIOD-1, then wraps. Runs in both modes.
- Start event:
  - Free-run (i_trig_mode=0): counter==0.
  - Trigger (i_trig_mode=1): i_start==1.
  - In IDLE, a start event enters FETCH with o_addr=0 on the next cycle.
  - Not in IDLE: the event is ignored and o_overrun pulses on the next cycle.
  - After reset release in free-run mode, the first frame starts immediately because the counter is 0.
- States:
  - IDLE: sclk=0, dai=0, lat=0, busy=0.
  - FETCH: exactly 2 cycles. o_addr is stable; i_data is captured into the per-lane shift registers at the end of cycle 2. sclk=0, dai=0.
  - SHIFT: C_BPC bits, each 2*C_CLK_DIV cycles.
    - First C_CLK_DIV cycles: o_sclk=0, o_dai = current bit, which changes only at the start of a low phase.
    - Last C_CLK_DIV cycles: o_sclk=1, o_dai held.
  - End of SHIFT:
    - After the last bit, if addr==C_CHANNELS-1, go to LATCH.
    - Otherwise addr+1 and go to FETCH.
  - LATCH: o_lat=1 for C_LAT_CYCLES cycles, sclk=0, dai=0. Then IDLE, with o_done=1 on the first IDLE cycle.
- Bit order:
  - C_MSB_FIRST=1: bit C_BPC-1 down to 0.
  - Otherwise: bit 0 upward.
- Busy duration: busy cycles per frame = C_CHANNELS*(2+2*C_BPC*C_CLK_DIV) + C_LAT_CYCLES.
- Period overrun: if this exceeds C_FRAME_PERIOD, free-run starts that land during busy produce overrun pulses. The next frame begins at the first counter==0 seen in IDLE.
- Mode change: i_trig_mode is sampled only in IDLE. A change mid-frame does not affect the current frame.
- Reset mid-frame: o_sclk, o_lat and o_dai drop to 0 immediately; no partial latch is issued.
- Width rules:
  - Address and bit counters saturate-compare against constant terminals sized to their own widths.
  - C_CHANNELS need not be a power of two; o_addr never exceeds C_CHANNELS-1.

Test Plan:
- Reset release in free-run mode (C_LANES=2, C_CHANNELS=3, C_BPC=4, C_CLK_DIV=1, C_LAT_CYCLES=2, C_FRAME_PERIOD=64) -> o_busy rises the cycle after release and stays high exactly 3*(2+8)+2=32 cycles. Next frame starts at cycle 64.
- Buffer words lane0={0xA,0x3,0xF}, lane1={0x5,0xC,0x0}, MSB first -> o_dai[0] sampled on o_sclk rising edges = 1010 0011 1111; o_dai[1] = 0101 1100 0000. Exactly 12 sclk rises, then one o_lat pulse of 2 cycles, then o_done for 1 cycle.
- Same stimulus with C_MSB_FIRST=0 and C_CLK_DIV=3 -> lane0 = 0101 1100 1111. Each sclk phase lasts 3 cycles. Busy = 3*(2+24)+2 = 80 cycles.
- Trigger mode, i_start pulsed at a frame's cycle 5 and again at cycle 10 -> one frame only, o_overrun pulses once (cycle 11). A further i_start after o_done starts a new frame.
- C_FRAME_PERIOD=20 with the 32-cycle frame -> overrun pulse at each dropped wrap. Frames start only at counter==0 while IDLE; no frame is ever truncated.
- Assert i_rst_n low during SHIFT of channel 1 -> o_sclk, o_dai, o_lat, o_busy go 0 asynchronously. No o_lat pulse occurs before the fresh frame after release, and that frame restarts at o_addr=0.
